bit_serializer: RTL

Parallel-to-serial front end for the serial divisibility checker. It accepts a DATA_W-bit word with a bit length over a valid/ready handshake. It then streams the low `len` bits out MSB-first, one bit per cycle, with first/last framing. The downstream remainder FSM consumes `x_o` as its serial input and uses `x_first_o` to restart its remainder at REM_0.

---
 rtl/div_pkg.sv | 20 ++
 rtl/ser_hold_buf.sv | 41 ++++
 rtl/bit_serializer.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the serial divisibility checker and its bit serializer front end.
package div_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [1:0] {
    REM_0 = 2'd0,
    REM_1 = 2'd1,
    REM_2 = 2'd2
  } rem_state_t;

  // A length of zero or beyond the word width means "use the whole word".
  function automatic int unsigned ser_norm_len(input int unsigned len, input int unsigned data_w);
    return ((len == 0) || (len > data_w)) ? data_w : len;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry data+len skid register with valid/ready, used to preload the next serializer word.
module ser_hold_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic [LEN_W-1:0]  push_len,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [LEN_W-1:0]  pop_len
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;

  assign push_ready = ~valid_q;
  assign pop_valid  = valid_q;
  assign pop_data   = data_q;
  assign pop_len    = len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
    end else if (push_valid && push_ready) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
      len_q   <= push_len;
    end else if (pop_ready && valid_q) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: streams the low len bits of a word MSB-first with first/last framing.
// Define SER_PRELOAD_EN to add a one-entry hold register for zero-bubble back-to-back words.
module bit_serializer
  import div_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [LEN_W-1:0]  in_len_i,
  output logic              x_o,
  output logic              x_valid_o,
  output logic              x_first_o,
  output logic              x_last_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  ser_state_t        state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [LEN_W-1:0]  count;
  logic              first_flag;

  logic              shifting, bit_hs, last_hs, accept;
  logic              load_direct, load, hold_valid, hold_pop;
  logic [LEN_W-1:0]  in_len_n, src_len, shamt;
  logic [DATA_W-1:0] src_data, shreg_load;

  assign in_len_n = LEN_W'(ser_norm_len(32'(in_len_i), DATA_W));
  assign shifting = (state == SER_SHIFT);
  assign bit_hs   = shifting & out_ready_i;
  assign last_hs  = bit_hs & (count == LEN_W'(1));

`ifdef SER_PRELOAD_EN
  logic              hold_push, hold_in_ready;
  logic [DATA_W-1:0] hold_data;
  logic [LEN_W-1:0]  hold_len;

  assign in_ready_o  = ~reset & hold_in_ready;
  assign accept      = in_valid_i & in_ready_o;
  // Direct load when idle, or bypass when the current word ends with nothing held.
  assign load_direct = accept & (~shifting | (last_hs & ~hold_valid));
  assign hold_push   = accept & ~load_direct;
  assign hold_pop    = last_hs & hold_valid;
  assign src_data    = hold_pop ? hold_data : in_data_i;
  assign src_len     = hold_pop ? hold_len  : in_len_n;

  ser_hold_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .push_valid (hold_push),
    .push_ready (hold_in_ready),
    .push_data  (in_data_i),
    .push_len   (in_len_n),
    .pop_valid  (hold_valid),
    .pop_ready  (hold_pop),
    .pop_data   (hold_data),
    .pop_len    (hold_len)
  );
`else
  assign in_ready_o  = ~reset & ~shifting;
  assign accept      = in_valid_i & in_ready_o;
  assign load_direct = accept;
  assign hold_valid  = 1'b0;
  assign hold_pop    = 1'b0;
  assign src_data    = in_data_i;
  assign src_len     = in_len_n;
`endif

  assign load       = load_direct | hold_pop;
  assign shamt      = LEN_W'(DATA_W) - src_len;
  assign shreg_load = src_data << shamt;

  always_ff @(posedge clk) begin
    if (reset) state <= SER_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE:  if (accept) state_nxt = SER_SHIFT;
      SER_SHIFT: if (last_hs && !load) state_nxt = SER_IDLE;
      default:   state_nxt = SER_IDLE;
    endcase
  end

  // Shift register, remaining-bit count and first-bit marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      count      <= '0;
      first_flag <= 1'b0;
    end else if (load) begin
      shreg      <= shreg_load;
      count      <= src_len;
      first_flag <= 1'b1;
    end else if (bit_hs) begin
      shreg      <= shreg << 1;
      count      <= count - LEN_W'(1);
      first_flag <= 1'b0;
    end
  end

  assign x_valid_o = shifting;
  assign x_o       = shifting & shreg[DATA_W-1];
  assign x_first_o = shifting & first_flag;
  assign x_last_o  = shifting & (count == LEN_W'(1));
  assign busy_o    = shifting | hold_valid;

endmodule
